// File: rtl/clock_switch_pkg.sv
// Shared definitions for the clock-switch request controller: select codes,
// FSM state encoding and the select legality helper.
package clock_switch_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_800     = 2'b00;
  localparam sel_t SEL_500     = 2'b01;
  localparam sel_t SEL_1000    = 2'b10;
  localparam sel_t SEL_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic sel_legal(input sel_t sel);
    return sel != SEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/clock_switch_ctrl_if.sv
// Request channel into the clock-switch controller.
// Handshake: a request transfers on any rising clk edge where req_valid and
// req_ready are both high; the requester holds req_sel stable while req_valid
// is high and req_ready is low.
interface clock_switch_ctrl_if;
  import clock_switch_pkg::*;

  logic req_valid;
  logic req_ready;
  sel_t req_sel;

  modport master (output req_valid, output req_sel, input req_ready);
  modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/clock_switch_ctrl.sv
// Drives clk_sel of the 3-source glitch-free clock switch and holds it for a
// guard interval so the switch's hand-over synchronizers settle before done.
module clock_switch_ctrl
  import clock_switch_pkg::*;
#(
    parameter int GUARD_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    clock_switch_ctrl_if.slave        req,
    output sel_t                      clk_sel,
    output sel_t                      cur_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output state_t                    dbg_state
);

    // Loaded on entry to WAIT; done fires on the cycle the counter is seen at 0.
    localparam logic [CNT_W-1:0] GUARD_INIT = CNT_W'(GUARD_CYCLES - 1);

    state_t           state_q, state_d;
    sel_t             clk_sel_q, clk_sel_d;
    sel_t             cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clk_sel_q <= SEL_800;
            cur_sel_q <= SEL_800;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_sel_q <= clk_sel_d;
            cur_sel_q <= cur_sel_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_sel_d = clk_sel_q;
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    if (!sel_legal(req.req_sel)) begin
                        err_d = 1'b1;
                    end else if (req.req_sel == cur_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        clk_sel_d = req.req_sel;
                        cnt_d     = GUARD_INIT;
                        busy_d    = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // clk_sel is frozen here; only the counter moves.
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    cur_sel_d = clk_sel_q;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req.req_ready = (state_q == ST_IDLE);
    assign clk_sel       = clk_sel_q;
    assign cur_sel       = cur_sel_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/clock_switch_ctrl.md
Name: clock_switch_ctrl

Overview:
Request-side controller that drives the 2-bit clk_sel of the 3-source glitch-free clock switch (800M/500M/1000M).
- Accepts switch requests over a valid/ready handshake from a free-running control clock.
- Rejects illegal codes.
- Holds clk_sel stable for a programmable guard interval while the switch's hand-over synchronizers settle, then reports completion.
- Sits between power/clock-management logic and the clock switch.

Parameters:
GUARD_CYCLES, 16, control-clock cycles clk_sel is held after a change before done; legal range 1..2^CNT_W.
CNT_W, 8, guard counter width.

Ports:
clk  input  1  control clock, free-running, independent of all switched clocks
rst  input  1  synchronous active-high reset
req_valid  input  1  switch request valid
req_ready  output  1  controller can accept a request
req_sel  input  2  requested source: 00=800M, 01=500M, 10=1000M, 11=illegal
clk_sel  output  2  select to clock switch, registered
cur_sel  output  2  last confirmed (settled) selection
busy  output  1  guard interval in progress
done  output  1  one-cycle pulse: request completed (switched or already selected)
err  output  1  one-cycle pulse: request rejected (req_sel==11)

Behaviour:
- Reset (sync, high) values: state=IDLE, clk_sel=00, cur_sel=00, cnt=0, busy=0, done=0, err=0, req_ready=1.
  - rst mid-WAIT aborts immediately to these values.
  - No done is issued for the aborted request.
- States: IDLE, WAIT.
- req_ready = (state==IDLE), combinational from state. Handshake = req_valid & req_ready at a rising clk edge.
- IDLE on handshake, decided on the same edge:
  - req_sel==11: err=1 for the next cycle; clk_sel and cur_sel unchanged; stay IDLE.
  - req_sel==cur_sel: done=1 for the next cycle; no guard; stay IDLE.
  - otherwise: clk_sel<=req_sel, cnt<=GUARD_CYCLES-1, busy<=1, state<=WAIT.
- WAIT:
  - req_ready=0; req_valid is ignored, and the requester must hold the request.
  - If cnt==0: state<=IDLE, busy<=0, cur_sel<=clk_sel, done<=1 for one cycle.
  - Else: cnt<=cnt-1.
- Latency, with the handshake at edge E0:
  - clk_sel changes after E0.
  - done and cur_sel update after edge E0+GUARD_CYCLES.
  - req_ready returns high in the same cycle done is high.
  - Back-to-back: a new handshake is allowed in the done cycle. Its done/err is produced independently.
- done and err are never both high. They are cleared every cycle unless set as above.
- clk_sel changes only on an accepted legal, different request. It never changes in WAIT.
- The counter never wraps; GUARD_CYCLES=1 gives exactly one WAIT cycle.
- Sizing rule: GUARD_CYCLES*Tclk must cover at least one posedge plus negedge of the slowest source (500M) for both the release and the acquire chains, plus margin.

Decomposition:
- Shared package clock_switch_pkg:
  - SEL_800=2'b00, SEL_500=2'b01, SEL_1000=2'b10, SEL_ILLEGAL=2'b11.
  - State encoding IDLE/WAIT.
  - Helper function sel_legal(sel).
- Single module; no sub-module. The guard counter is inline.

Test Plan:
- Reset, then release rst → clk_sel=00, cur_sel=00, req_ready=1, busy=0, done=0, err=0.
- GUARD_CYCLES=4; request 10 accepted at E0 → clk_sel=10 after E0; busy=1 for 4 cycles; done pulse and cur_sel=10 after E4; req_ready=1 with done.
- Request 00 while cur_sel=00 → done pulse the next cycle, busy never high, clk_sel stays 00.
- Request 11 → err pulse the next cycle, no done, clk_sel/cur_sel unchanged; then request 01 → normal switch to 01.
- During WAIT, toggle req_valid with req_sel=10 → req_ready=0, clk_sel held, no extra done; after done, a back-to-back handshake with 10 completes a full second guard.
- Assert rst at cycle 2 of WAIT (switching 00→01) → next cycle clk_sel=00, cur_sel=00, busy=0, no done pulse.
